// File: rtl/spike_pkg.sv
// Shared spike-path definitions: default tag/count widths, the tag/count
// record payload and the saturating-count limit helper.
package spike_pkg;

  localparam int unsigned NTAG_DEF = 10;
  localparam int unsigned NCT_DEF  = 10;

  typedef struct packed {
    logic [NTAG_DEF-1:0] tag;
    logic [NCT_DEF-1:0]  ct;
  } tag_ct_t;

  function automatic int unsigned ct_max(input int unsigned nct);
    return (32'd1 << nct) - 32'd1;
  endfunction

endpackage

// File: rtl/vr_pipe_reg.sv
// One-entry valid/ready register with a parameterized payload type.
// Accepts a new word whenever empty or when the held word drains the same cycle.
module vr_pipe_reg
  import spike_pkg::*;
#(
  parameter type T = tag_ct_t
) (
  input  logic clk,
  input  logic reset,
  input  logic in_v,
  output logic in_r,
  input  T     in_data,
  output logic out_v,
  input  logic out_r,
  output T     out_data
);

  logic v_q, v_d;
  T     data_q, data_d;

  assign in_r     = !v_q || out_r;
  assign out_v    = v_q;
  assign out_data = data_q;

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (in_v && in_r) begin
      v_d    = 1'b1;
      data_d = in_data;
    end else if (out_r) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/tag_ct_coalescer.sv
// Merges runs of identical spike tags into (tag, count) records for the filter
// array, with idle-timeout eviction and a flush/drain handshake.
module tag_ct_coalescer
  import spike_pkg::*;
#(
  parameter int unsigned NTAG         = NTAG_DEF,
  parameter int unsigned NCT          = NCT_DEF,
  parameter int unsigned IDLE_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NTAG-1:0] in_tag,
  input  logic            in_v,
  output logic            in_r,
  output logic [NTAG-1:0] out_tag,
  output logic [NCT-1:0]  out_ct,
  output logic            out_v,
  input  logic            out_r,
  input  logic            flush,
  output logic            flush_done
);

  localparam logic [NCT-1:0] CT_MAX = NCT'(ct_max(NCT));
  localparam int unsigned IW    = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned IT_M1 = (IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1;
  // The decision cycle itself counts as the last idle cycle.
  localparam logic [IW-1:0] IDLE_LIM = IW'(IT_M1);

  typedef struct packed {
    logic [NTAG-1:0] tag;
    logic [NCT-1:0]  ct;
  } rec_t;

  logic            hold_v_q, hold_v_d;
  logic [NTAG-1:0] hold_tag_q, hold_tag_d;
  logic [NCT-1:0]  hold_ct_q, hold_ct_d;
  logic            flush_pend_q, flush_pend_d;
  logic            flush_done_q, flush_done_d;
  logic [IW-1:0]   idle_q, idle_d;

  logic slot_free, accept, merge, evict_acc, timeout_hit, evict, out_v_d;
  rec_t rec_in, rec_out;

  assign in_r        = (!hold_v_q || slot_free) && !flush && !flush_pend_q;
  assign accept      = in_v && in_r;
  assign merge       = hold_v_q && (in_tag == hold_tag_q) && (hold_ct_q != CT_MAX);
  assign evict_acc   = accept && hold_v_q && !merge;
  assign timeout_hit = (IDLE_TIMEOUT != 0) && (idle_q == IDLE_LIM);
  assign evict       = evict_acc ||
                       (!accept && hold_v_q && slot_free && (flush_pend_q || timeout_hit));
  assign out_v_d     = evict || (out_v && !out_r);
  assign flush_done  = flush_done_q;

  // Hold register, idle counter and flush bookkeeping.
  always_comb begin
    hold_v_d     = hold_v_q;
    hold_tag_d   = hold_tag_q;
    hold_ct_d    = hold_ct_q;
    idle_d       = idle_q;
    if (accept) begin
      hold_v_d   = 1'b1;
      hold_tag_d = in_tag;
      hold_ct_d  = merge ? hold_ct_q + NCT'(1) : NCT'(1);
    end else if (evict) begin
      hold_v_d   = 1'b0;
    end
    if (accept || !hold_v_q) begin
      idle_d = '0;
    end else if (idle_q != IDLE_LIM) begin
      idle_d = idle_q + IW'(1);
    end
    flush_pend_d = (flush_pend_q && !flush_done_q) || (flush && !flush_pend_q);
    // Registered form of "pending with nothing held or queued" next cycle.
    flush_done_d = flush_pend_d && !hold_v_d && !out_v_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_v_q     <= 1'b0;
      hold_tag_q   <= '0;
      hold_ct_q    <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      idle_q       <= '0;
    end else begin
      hold_v_q     <= hold_v_d;
      hold_tag_q   <= hold_tag_d;
      hold_ct_q    <= hold_ct_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
      idle_q       <= idle_d;
    end
  end

  assign rec_in.tag = hold_tag_q;
  assign rec_in.ct  = hold_ct_q;

  vr_pipe_reg #(
    .T(rec_t)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .in_v     (evict),
    .in_r     (slot_free),
    .in_data  (rec_in),
    .out_v    (out_v),
    .out_r    (out_r),
    .out_data (rec_out)
  );

  assign out_tag = rec_out.tag;
  assign out_ct  = rec_out.ct;

endmodule

// File: tb/tb_tag_ct_coalescer.sv
// Directed bench: u0 (NCT=3, IDLE_TIMEOUT=4) and u1 (NCT=10, timeout disabled)
// share stimulus; u0 records are collected and compared against hand lists.
module tb_tag_ct_coalescer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] in_tag;
  logic       in_v, out_r, flush;

  logic       in_r0, out_v0, flush_done0;
  logic [9:0] out_tag0;
  logic [2:0] out_ct0;
  logic       in_r1, out_v1, flush_done1;
  logic [9:0] out_tag1;
  logic [9:0] out_ct1;

  int n_vec = 0;
  int n_err = 0;
  int q_tag[$], q_ct[$], e_tag[$], e_ct[$];

  always #5 clk = ~clk;

  tag_ct_coalescer #(.NTAG(10), .NCT(3), .IDLE_TIMEOUT(4)) u0 (
    .clk(clk), .reset(reset), .in_tag(in_tag), .in_v(in_v), .in_r(in_r0),
    .out_tag(out_tag0), .out_ct(out_ct0), .out_v(out_v0), .out_r(out_r),
    .flush(flush), .flush_done(flush_done0)
  );

  tag_ct_coalescer #(.NTAG(10), .NCT(10), .IDLE_TIMEOUT(0)) u1 (
    .clk(clk), .reset(reset), .in_tag(in_tag), .in_v(in_v), .in_r(in_r1),
    .out_tag(out_tag1), .out_ct(out_ct1), .out_v(out_v1), .out_r(out_r),
    .flush(flush), .flush_done(flush_done1)
  );

  always @(posedge clk) begin
    if (!reset && out_v0 && out_r) begin
      q_tag.push_back(int'(out_tag0));
      q_ct.push_back(int'(out_ct0));
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic expect_rec(input int t, input int c);
    e_tag.push_back(t);
    e_ct.push_back(c);
  endtask

  task automatic check_recs(input string nm);
    chk({nm, "_nrec"}, 32'(q_tag.size()), 32'(e_tag.size()));
    for (int i = 0; i < e_tag.size(); i++) begin
      if (i < q_tag.size()) begin
        chk($sformatf("%s_tag%0d", nm, i), 32'(q_tag[i]), 32'(e_tag[i]));
        chk($sformatf("%s_ct%0d", nm, i), 32'(q_ct[i]), 32'(e_ct[i]));
      end
    end
    q_tag.delete(); q_ct.delete(); e_tag.delete(); e_ct.delete();
  endtask

  task automatic send(input int t);
    in_v   = 1'b1;
    in_tag = 10'(t);
    @(negedge clk);
  endtask

  // Called at a negedge; returns one cycle after the flush_done pulse.
  task automatic do_flush(input string nm, input int budget);
    bit done = 0;
    in_v  = 1'b0;
    flush = 1'b1;
    #1 chk({nm, "_inr_req"}, 32'(in_r0), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (flush_done0) done = 1;
      else begin
        #1 chk({nm, "_inr_blk"}, 32'(in_r0), 32'd0);
        @(negedge clk);
      end
    end
    chk({nm, "_done_seen"}, 32'(done), 32'd1);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(flush_done0), 32'd0);
    #1 chk({nm, "_inr_after"}, 32'(in_r0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset = 1'b1; in_v = 1'b0; in_tag = '0; out_r = 1'b1; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outv", 32'(out_v0), 32'd0);
    chk("rst_outtag", 32'(out_tag0), 32'd0);
    chk("rst_outct", 32'(out_ct0), 32'd0);
    chk("rst_done", 32'(flush_done0), 32'd0);
    reset = 1'b0;
    #1 chk("rst_inr", 32'(in_r0), 32'd1);
    @(negedge clk);

    // Merge: 5,5,5,7 -> (5,3),(7,1)
    send(5); send(5); send(5); send(7);
    do_flush("merge", 20);
    expect_rec(5, 3); expect_rec(7, 1);
    check_recs("merge");

    // Saturation at CT_MAX=7: nine 2s -> (2,7),(2,2)
    for (int i = 0; i < 9; i++) send(2);
    do_flush("sat", 20);
    expect_rec(2, 7); expect_rec(2, 2);
    check_recs("sat");

    // Backpressure: 1 in output, 2 held, 3 blocked
    out_r = 1'b0;
    send(1); send(2);
    in_v = 1'b1; in_tag = 10'd3;
    #1 chk("bp_inr_blk", 32'(in_r0), 32'd0);
    repeat (3) @(negedge clk);
    chk("bp_outv", 32'(out_v0), 32'd1);
    chk("bp_outtag", 32'(out_tag0), 32'd1);
    chk("bp_outct", 32'(out_ct0), 32'd1);
    #1 chk("bp_inr_stall", 32'(in_r0), 32'd0);
    out_r = 1'b1;
    #1 chk("bp_inr_rel", 32'(in_r0), 32'd1);
    @(negedge clk);
    do_flush("bp", 20);
    expect_rec(1, 1); expect_rec(2, 1); expect_rec(3, 1);
    check_recs("bp");

    // Timeout: accept 9 in cycle A -> out_v at A+5 only on u0
    send(9);
    in_v = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("to_outv_a%0d", k), 32'(out_v0), 32'(k == 5));
      if (k == 5) begin
        chk("to_outtag", 32'(out_tag0), 32'd9);
        chk("to_outct", 32'(out_ct0), 32'd1);
      end
      @(negedge clk);
    end
    expect_rec(9, 1);
    check_recs("to");

    // Timeout disabled: u1 keeps holding tag 9
    cnt = 0;
    repeat (100) begin
      if (out_v1) cnt++;
      @(negedge clk);
    end
    chk("nto_quiet", 32'(cnt), 32'd0);
    #1 chk("nto_inr", 32'(in_r1), 32'd1);

    // Flush with nothing held on u0; u1 drains its held 9
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("idle_done", 32'(flush_done0), 32'd1);
    chk("idle_outv", 32'(out_v0), 32'd0);
    @(negedge clk);
    chk("idle_done_pulse", 32'(flush_done0), 32'd0);
    chk("nto_outv", 32'(out_v1), 32'd1);
    chk("nto_outtag", 32'(out_tag1), 32'd9);
    chk("nto_outct", 32'(out_ct1), 32'd1);
    @(negedge clk);
    chk("nto_done", 32'(flush_done1), 32'd1);
    check_recs("idle");

    // Reset mid-stream discards queued (4,1) and held (6,1)
    out_r = 1'b0;
    send(4); send(6);
    in_v = 1'b0;
    chk("mrst_pre_outv", 32'(out_v0), 32'd1);
    reset = 1'b1;
    #1;
    chk("mrst_outv", 32'(out_v0), 32'd0);
    chk("mrst_outtag", 32'(out_tag0), 32'd0);
    chk("mrst_outct", 32'(out_ct0), 32'd0);
    chk("mrst_done", 32'(flush_done0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_r = 1'b1;
    #1 chk("mrst_inr", 32'(in_r0), 32'd1);
    repeat (20) @(negedge clk);
    chk("mrst_quiet", 32'(out_v0), 32'd0);
    check_recs("mrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tag_ct_coalescer.md
# tag_ct_coalescer

Producer-side counterpart of the spike filter array's tag/count input channel. Accepts single spike events (one tag per handshake) from the spike decode path, merges runs of identical tags into one (tag, count) record, and emits the records on a tag/count valid/ready channel for the filter array. A flush handshake drains pending counts so the controller can issue the filter update pulse on a clean boundary.

## Interface

Parameters:
- NTAG, 10, tag width (filter index width).
- NCT, 10, count width; max count CT_MAX = 2^NCT-1.
- IDLE_TIMEOUT, 64, idle cycles before a held record is emitted; 0 disables timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- in_tag  in  NTAG  spike tag, one spike per transfer.
- in_v  in  1  input valid.
- in_r  out  1  input ready.
- out_tag  out  NTAG  record tag.
- out_ct  out  NCT  record count, never 0 when out_v=1.
- out_v  out  1  output valid.
- out_r  in  1  output ready from filter array.
- flush  in  1  single-cycle request to drain pending counts.
- flush_done  out  1  single-cycle pulse: no counts held or queued.

## Operation

- State: hold register (hold_v, hold_tag, hold_ct), output register (out_v, out_tag, out_ct), flush_pending, idle counter.
- Slot free: slot_free = !out_v || out_r.
- Input ready: in_r = (!hold_v || slot_free) && !flush && !flush_pending. No dependence on in_tag.
- Accept = in_v && in_r:
  - hold empty: load tag, ct=1.
  - hold_v, same tag, hold_ct < CT_MAX: hold_ct += 1.
  - hold_v, different tag or hold_ct == CT_MAX: evict hold to output register; load new tag, ct=1, same cycle.
- Eviction without accept (needs hold_v && slot_free): flush_pending set, or idle counter == IDLE_TIMEOUT (nonzero). Hold cleared.
- Idle counter: cleared on accept or when hold empty; increments each cycle hold_v && no accept; saturates at IDLE_TIMEOUT.
- Output register: loads on eviction; clears out_v on out_r with no eviction. Standard valid/ready: out_tag/out_ct stable while out_v && !out_r.
- Flush: flush at cycle t sets flush_pending at t+1 (ignored if already pending). While pending, input blocked; hold evicted when slot free. flush_done pulses on the cycle flush_pending && !hold_v && !out_v; flush_pending clears same edge. Flush with nothing held: flush_done at t+1.
- Counts: hold_ct arithmetic unsigned NCT bits; saturation forces eviction, never wraps.

## Timing

- Reset values: out_v=0, out_tag=0, out_ct=0, flush_done=0, hold_v=0, flush_pending=0, idle counter=0; in_r=1 once reset deasserts (combinational).
- Reset mid-operation discards held and queued counts; no record emitted afterward for them.
- Eviction decided in cycle E -> out_v=1 in cycle E+1.
- Timeout: last accept in cycle A -> eviction decided at A+IDLE_TIMEOUT -> out_v at A+IDLE_TIMEOUT+1 (slot free assumed).
- Throughput: one input per cycle while output not stalled; one record per cycle max.
- Simultaneous accept+evict, flush+accept (flush wins: in_r=0 that cycle), timeout+accept (accept wins, counter cleared) as above.

## Structure

- Shared package spike_pkg: NTAG/NCT defaults, tag_ct_t struct {tag, ct}, CT_MAX function.
- Sub-module: vr_pipe_reg (one-entry valid/ready register, parameterized payload) for the output register; reusable elsewhere.

## Test plan

- Reset: assert reset mid-stream -> out_v=0, out_tag=0, out_ct=0, flush_done=0; after deassert in_r=1.
- Merge: out_r=1, tags 5,5,5,7 back-to-back, then flush -> records (5,3),(7,1), then flush_done pulse, in_r=0 until flush_done.
- Saturation (NCT=3): 9 events of tag 2, then flush -> (2,7),(2,2).
- Backpressure: out_r=0, tags 1,2,3 -> 1 in output, 2 held, in_r=0 with 3 pending; out_r=1 -> (1,1),(2,1),(3,1) in order, none lost.
- Timeout (IDLE_TIMEOUT=4): single tag 9 accepted cycle A -> out_v with (9,1) at A+5; IDLE_TIMEOUT=0 -> no emission for 100 cycles.
- Flush idle: flush with nothing held -> flush_done next cycle, no out_v.
